// File: rtl/mul_hilo_unit_pkg.sv
// rtl/mul_hilo_unit_pkg.sv - shared encodings for the HI/LO multiply unit
//
// Purpose:
//   State encodings, step count and HI/LO select encodings used by the
//   multiply unit, its bus interface and any datapath that talks to it.
// Contents:
//   md_state_t  IDLE / RUN / FIN state encodings
//   MD_STEPS    number of shift-add steps for the default 32-bit operand
//   SEL_LO      rd_sel / mt_sel value that addresses LO
//   SEL_HI      rd_sel / mt_sel value that addresses HI

package mul_hilo_unit_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIN  = 2'd2
    } md_state_t;

    localparam int MD_STEPS = 32;

    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

endpackage

// File: rtl/mul_hilo_unit_if.sv
// rtl/mul_hilo_unit_if.sv - datapath-side bus of the HI/LO multiply unit
//
// Purpose:
//   Groups the multiply request, MFHI/MFLO read, MTHI/MTLO write and
//   status signals between the datapath (master) and the unit (slave).
// Signals:
//   start, is_signed, a, b   multiply request and operands
//   rd_en, rd_sel, rd_data   HI/LO read port (rd_data is combinational)
//   mt_we, mt_sel, mt_data   HI/LO write port
//   busy, done, stall        unit status towards the pipeline

interface mul_hilo_unit_if #(
    parameter int WIDTH = 32
);

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             rd_en;
    logic             rd_sel;
    logic [WIDTH-1:0] rd_data;
    logic             mt_we;
    logic             mt_sel;
    logic [WIDTH-1:0] mt_data;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, is_signed, a, b,
        output rd_en, rd_sel,
        input  rd_data,
        output mt_we, mt_sel, mt_data,
        input  busy, done, stall
    );

    modport slave (
        input  start, is_signed, a, b,
        input  rd_en, rd_sel,
        output rd_data,
        input  mt_we, mt_sel, mt_data,
        output busy, done, stall
    );

endinterface

// File: rtl/mul_hilo_unit_adder.sv
// rtl/mul_hilo_unit_adder.sv - WIDTH-bit adder with carry out for one multiply step
//
// Purpose:
//   Adds the multiplicand into the upper half of the partial product.
// Ports:
//   a, b   in   WIDTH  addends
//   sum    out  WIDTH  a + b modulo 2**WIDTH
//   cout   out  1      carry out of the top bit

module mul_hilo_unit_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mul_hilo_unit.sv
// rtl/mul_hilo_unit.sv - iterative radix-2 multiplier owning the HI/LO registers
//
// Purpose:
//   Serves MULT/MULTU requests with a shift-add engine (one multiplier bit
//   per clock) and MFHI/MFLO/MTHI/MTLO accesses. The product lands in
//   {HI,LO} 33 edges after the accepting edge; stall tells the datapath to
//   hold any instruction that touches the unit while it is busy.
// Ports:
//   clk    in     system clock, rising edge
//   reset  in     synchronous, active-high; discards an in-flight multiply
//   bus    slave  start/is_signed/a/b, rd_en/rd_sel/rd_data,
//                 mt_we/mt_sel/mt_data, busy/done/stall

module mul_hilo_unit
    import mul_hilo_unit_pkg::*;
#(
    parameter int WIDTH = MD_STEPS
) (
    input  logic           clk,
    input  logic           reset,
    mul_hilo_unit_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    md_state_t          state_q;
    md_state_t          state_d;

    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] result;
    logic               neg_q;
    logic [CNT_W-1:0]   count_q;
    logic               done_q;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic               last_step;
    logic               busy;

    // Unsigned magnitude of an operand. The most negative value negates to
    // itself, which read as unsigned is exactly its magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    mul_hilo_unit_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (acc_q[2*WIDTH-1:WIDTH]),
        .b    (mcand_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // One shift-add step: optionally add the multiplicand into the upper
    // half, then shift {carry, acc} right by one so the carry is kept.
    always_comb begin
        acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
        if (mplier_q[0]) begin
            acc_step = {add_cout, add_sum, acc_q[WIDTH-1:1]};
        end
    end

    assign last_step = (count_q == CNT_W'(WIDTH - 1));
    assign result    = neg_q ? -acc_q : acc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (bus.start) begin
                    state_d = MD_RUN;
                end
            end
            MD_RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_d = MD_FIN;
                end
            end
            MD_FIN: begin
                busy    = 1'b1;
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_q == MD_FIN);
            case (state_q)
                MD_IDLE: begin
                    // A start takes priority over a same-cycle MT write.
                    if (bus.start) begin
                        mcand_q  <= magnitude(bus.a, bus.is_signed);
                        mplier_q <= magnitude(bus.b, bus.is_signed);
                        neg_q    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        acc_q    <= '0;
                        count_q  <= '0;
                    end else if (bus.mt_we) begin
                        if (bus.mt_sel == SEL_HI) begin
                            hi_q <= bus.mt_data;
                        end else begin
                            lo_q <= bus.mt_data;
                        end
                    end
                end
                MD_RUN: begin
                    acc_q    <= acc_step;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + CNT_W'(1);
                end
                MD_FIN: begin
                    {hi_q, lo_q} <= result;
                end
                default: begin
                end
            endcase
        end
    end

    // rd_data always shows the architectural registers, never acc_q, so a
    // stalled reader sees the previous HI/LO rather than a partial product.
    assign bus.rd_data = (bus.rd_sel == SEL_HI) ? hi_q : lo_q;
    assign bus.busy    = busy;
    assign bus.done    = done_q;
    assign bus.stall   = busy & (bus.start | bus.rd_en | bus.mt_we);

endmodule

// File: tb/tb_mul_hilo_unit.sv
// tb/tb_mul_hilo_unit.sv - self-checking bench for mul_hilo_unit

module tb_mul_hilo_unit;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          rd_from;
        logic        rd_sel;
        int          start_at;
        int          mt_at;
        logic        mt_with_start;
        logic        b2b;
    } vec_t;

    logic clk;
    logic reset;

    int checks;
    int failures;

    logic [31:0] model_hi;
    logic [31:0] model_lo;
    logic [63:0] sb[$];
    vec_t        vecs[10];

    mul_hilo_unit_if #(.WIDTH(32)) bus ();

    mul_hilo_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] x,
                                            input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        if (sgn) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    function automatic vec_t mk(input string name, input logic sgn, input logic [31:0] a,
                                input logic [31:0] b, input logic [63:0] exp);
        vec_t v;
        v.name = name; v.sgn = sgn; v.a = a; v.b = b; v.exp = exp;
        v.rd_from = 0; v.rd_sel = 1'b0; v.start_at = 0; v.mt_at = 0;
        v.mt_with_start = 1'b0; v.b2b = 1'b0;
        return v;
    endfunction

    // Drives one multiply, plays the side requests of the vector while the
    // unit is busy, then checks timing and the scoreboarded product.
    task automatic run_mul(input vec_t v, input bit next_b2b);
        logic [63:0] exp;
        logic [31:0] got_hi;
        logic [31:0] got_lo;
        int cyc;
        int busy_cnt;
        if (!v.b2b) @(negedge clk);
        bus.start = 1'b1; bus.is_signed = v.sgn; bus.a = v.a; bus.b = v.b;
        bus.mt_we = v.mt_with_start; bus.mt_sel = 1'b1; bus.mt_data = 32'hCAFEF00D;
        sb.push_back(v.exp);
        #1 chk({v.name, "/stall_idle"}, 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.start = 1'b0; bus.mt_we = 1'b0;
        bus.a = $urandom; bus.b = $urandom;
        cyc = 0;
        busy_cnt = 0;
        while (!bus.done && cyc < 100) begin
            cyc++;
            if (bus.busy) busy_cnt++;
            bus.start   = (cyc == v.start_at);
            bus.mt_we   = (cyc == v.mt_at);
            bus.mt_sel  = 1'b0;
            bus.mt_data = 32'hDEADBEEF;
            bus.rd_en   = (v.rd_from > 0) && (cyc >= v.rd_from);
            bus.rd_sel  = v.rd_sel;
            #1;
            chk($sformatf("%s/stall_c%0d", v.name, cyc), 64'(bus.stall),
                64'(bus.start | bus.rd_en | bus.mt_we));
            if (bus.rd_en) begin
                chk($sformatf("%s/rd_old_c%0d", v.name, cyc), 64'(bus.rd_data),
                    64'(v.rd_sel ? model_hi : model_lo));
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.mt_we = 1'b0;
        chk({v.name, "/cycles_to_done"}, 64'(cyc), 64'd33);
        chk({v.name, "/busy_cycles"}, 64'(busy_cnt), 64'd33);
        #1;
        chk({v.name, "/busy_at_done"}, 64'(bus.busy), 64'd0);
        if (bus.rd_en) begin
            chk({v.name, "/stall_at_done"}, 64'(bus.stall), 64'd0);
        end
        if (sb.size() == 0) begin
            chk({v.name, "/scoreboard_empty"}, 64'd1, 64'd0);
            exp = '0;
        end else begin
            exp = sb.pop_front();
        end
        bus.rd_sel = 1'b1;
        #1 got_hi = bus.rd_data;
        bus.rd_sel = 1'b0;
        #1 got_lo = bus.rd_data;
        bus.rd_en = 1'b0;
        chk({v.name, "/hilo"}, {got_hi, got_lo}, exp);
        {model_hi, model_lo} = exp;
        if (!next_b2b) begin
            @(negedge clk);
            chk({v.name, "/done_one_cycle"}, 64'(bus.done), 64'd0);
            chk({v.name, "/idle_after"}, 64'(bus.busy), 64'd0);
        end
    endtask

    initial begin
        bit done_seen;
        checks = 0;
        failures = 0;
        model_hi = '0;
        model_lo = '0;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;
        bus.rd_en = 1'b0; bus.rd_sel = 1'b0;
        bus.mt_we = 1'b0; bus.mt_sel = 1'b0; bus.mt_data = '0;

        vecs[0] = mk("multu_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        vecs[1] = mk("mult_m3x5", 1'b1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
        vecs[2] = mk("mult_minxmin", 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        vecs[3] = mk("rd_hi_and_start_mid", 1'b0, 32'h12345678, 32'h9ABCDEF0,
                     ref_mul(1'b0, 32'h12345678, 32'h9ABCDEF0));
        vecs[3].rd_from = 10; vecs[3].rd_sel = 1'b1; vecs[3].start_at = 15;
        vecs[4] = mk("zero_mt_busy", 1'b1, 32'd0, 32'hFFFFFFFF, 64'd0);
        vecs[4].mt_at = 5; vecs[4].rd_from = 6; vecs[4].rd_sel = 1'b0;
        vecs[5] = mk("b2b_start", 1'b1, 32'h7FFFFFFF, 32'h80000000,
                     ref_mul(1'b1, 32'h7FFFFFFF, 32'h80000000));
        vecs[5].b2b = 1'b1;
        vecs[6] = mk("start_with_mt", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1);
        vecs[6].mt_with_start = 1'b1; vecs[6].rd_from = 2; vecs[6].rd_sel = 1'b1;
        for (int i = 7; i < 10; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rs;
            ra = $urandom;
            rb = $urandom;
            rs = (i % 2) == 1;
            vecs[i] = mk($sformatf("rand%0d", i), rs, ra, rb, ref_mul(rs, ra, rb));
        end

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset/busy", 64'(bus.busy), 64'd0);
        chk("reset/done", 64'(bus.done), 64'd0);
        chk("reset/stall", 64'(bus.stall), 64'd0);
        bus.rd_sel = 1'b1;
        #1 chk("reset/hi", 64'(bus.rd_data), 64'd0);
        bus.rd_sel = 1'b0;
        #1 chk("reset/lo", 64'(bus.rd_data), 64'd0);

        for (int i = 0; i < 10; i++) begin
            run_mul(vecs[i], (i + 1 < 10) ? vecs[i + 1].b2b : 1'b0);
        end

        // Reset part-way through a multiply.
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'h0000FFFF; bus.b = 32'h00FF00FF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset/busy", 64'(bus.busy), 64'd0);
        chk("midreset/done", 64'(bus.done), 64'd0);
        bus.rd_sel = 1'b1;
        #1 chk("midreset/hi", 64'(bus.rd_data), 64'd0);
        bus.rd_sel = 1'b0;
        #1 chk("midreset/lo", 64'(bus.rd_data), 64'd0);
        model_hi = '0;
        model_lo = '0;
        done_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) done_seen = 1'b1;
        end
        chk("midreset/no_done", 64'(done_seen), 64'd0);

        run_mul(mk("multu_7x6", 1'b0, 32'd7, 32'd6, 64'd42), 1'b0);

        // Idle MTLO / MFLO and MTHI / MFHI.
        @(negedge clk);
        bus.mt_we = 1'b1; bus.mt_sel = 1'b0; bus.mt_data = 32'h12345678;
        #1 chk("mtlo/stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.mt_we = 1'b1; bus.mt_sel = 1'b1; bus.mt_data = 32'hA5A5C3C3;
        bus.rd_en = 1'b1; bus.rd_sel = 1'b0;
        #1;
        chk("mflo/data", 64'(bus.rd_data), 64'h12345678);
        chk("mflo/stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.mt_we = 1'b0;
        bus.rd_sel = 1'b1;
        #1;
        chk("mfhi/data", 64'(bus.rd_data), 64'hA5A5C3C3);
        bus.rd_sel = 1'b0;
        #1 chk("mflo/kept", 64'(bus.rd_data), 64'h12345678);
        bus.rd_en = 1'b0;

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
